// File: rtl/fft_output_streamer.sv
// Snapshots 16 complex FFT bins on start and streams them as rounded, saturated valid/ready beats.
// Define FFT_OUT_BITREV_EN to emit beats in bit-reversed bin order instead of natural order.
module fft_output_streamer #(
    parameter int N     = 16,
    parameter int INW   = 48,
    parameter int OUTW  = 16,
    parameter int SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*INW-1:0]       yr_flat,
    input  logic [N*INW-1:0]       yi_flat,
    input  logic                   start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OUTW-1:0] out_re,
    output logic signed [OUTW-1:0] out_im,
    output logic [3:0]             out_bin,
    output logic                   out_last,
    output logic                   out_sat,
    output logic                   busy,
    output logic                   done,
    output logic                   err_overrun
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic signed [INW:0] RND  = {{INW{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [INW:0] MAXV = {{(INW-OUTW+2){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [INW:0] MINV = {{(INW-OUTW+2){1'b1}}, {(OUTW-1){1'b0}}};

    // Returns {saturated, value}: round half up, arithmetic shift, then clamp to OUTW bits.
    function automatic logic [OUTW:0] scale(input logic signed [INW-1:0] x);
        logic signed [INW:0] r;
        r = ($signed({x[INW-1], x}) + RND) >>> SHIFT;
        if (r > MAXV)      scale = {1'b1, MAXV[OUTW-1:0]};
        else if (r < MINV) scale = {1'b1, MINV[OUTW-1:0]};
        else               scale = {1'b0, r[OUTW-1:0]};
    endfunction

    function automatic logic [3:0] bin_of(input logic [3:0] k);
`ifdef FFT_OUT_BITREV_EN
        bin_of = {k[0], k[1], k[2], k[3]};
`else
        bin_of = k;
`endif
    endfunction

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic signed [INW-1:0]  snap_re_q [N];
    logic signed [INW-1:0]  snap_re_d [N];
    logic signed [INW-1:0]  snap_im_q [N];
    logic signed [INW-1:0]  snap_im_d [N];
    logic                   out_valid_q, out_valid_d;
    logic signed [OUTW-1:0] out_re_q, out_re_d;
    logic signed [OUTW-1:0] out_im_q, out_im_d;
    logic [3:0]             out_bin_q, out_bin_d;
    logic                   out_last_q, out_last_d;
    logic                   out_sat_q, out_sat_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [3:0]             load_cnt;
    logic [3:0]             load_bin;
    logic signed [INW-1:0]  src_re;
    logic signed [INW-1:0]  src_im;
    logic [OUTW:0]          re_s;
    logic [OUTW:0]          im_s;

    // Beat 0 comes straight from the inputs since the snapshot is only written at the same edge.
    always_comb begin
        load_cnt = (state_q == IDLE) ? 4'd0 : cnt_q + 4'd1;
        load_bin = bin_of(load_cnt);
        if (state_q == IDLE) begin
            src_re = yr_flat[int'(load_bin)*INW +: INW];
            src_im = yi_flat[int'(load_bin)*INW +: INW];
        end else begin
            src_re = snap_re_q[load_bin];
            src_im = snap_im_q[load_bin];
        end
        re_s = scale(src_re);
        im_s = scale(src_im);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_re_d   = snap_re_q;
        snap_im_d   = snap_im_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_bin_d   = out_bin_q;
        out_last_d  = out_last_q;
        out_sat_d   = out_sat_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int g = 0; g < N; g++) begin
                        snap_re_d[g] = yr_flat[g*INW +: INW];
                        snap_im_d[g] = yi_flat[g*INW +: INW];
                    end
                    state_d     = STREAM;
                    cnt_d       = 4'd0;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    out_re_d    = re_s[OUTW-1:0];
                    out_im_d    = im_s[OUTW-1:0];
                    out_bin_d   = load_bin;
                    out_last_d  = 1'b0;
                    out_sat_d   = re_s[OUTW] | im_s[OUTW];
                end
            end
            STREAM: begin
                if (start) err_d = 1'b1;
                if (out_ready) begin
                    if (cnt_q == 4'd15) begin
                        state_d     = DONE;
                        cnt_d       = 4'd0;
                        done_d      = 1'b1;
                        out_valid_d = 1'b0;
                        out_re_d    = '0;
                        out_im_d    = '0;
                        out_bin_d   = 4'd0;
                        out_last_d  = 1'b0;
                        out_sat_d   = 1'b0;
                    end else begin
                        cnt_d      = load_cnt;
                        out_re_d   = re_s[OUTW-1:0];
                        out_im_d   = im_s[OUTW-1:0];
                        out_bin_d  = load_bin;
                        out_last_d = (load_cnt == 4'd15);
                        out_sat_d  = re_s[OUTW] | im_s[OUTW];
                    end
                end
            end
            DONE: begin
                if (start) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            for (int g = 0; g < N; g++) begin
                snap_re_q[g] <= '0;
                snap_im_q[g] <= '0;
            end
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_bin_q   <= 4'd0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_re_q   <= snap_re_d;
            snap_im_q   <= snap_im_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_bin_q   <= out_bin_d;
            out_last_q  <= out_last_d;
            out_sat_q   <= out_sat_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_re      = out_re_q;
    assign out_im      = out_im_q;
    assign out_bin     = out_bin_q;
    assign out_last    = out_last_q;
    assign out_sat     = out_sat_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_fft_output_streamer.sv
// Directed bench for fft_output_streamer; build with FFT_OUT_BITREV_EN to run the bit-reversed ordering case.
`timescale 1ns/1ps
module tb_fft_output_streamer;

    localparam int N    = 16;
    localparam int INW  = 48;
    localparam int OUTW = 16;
`ifdef FFT_OUT_BITREV_EN
    localparam int SH = 1;
`else
    localparam int SH = 4;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N*INW-1:0]       yr_flat;
    logic [N*INW-1:0]       yi_flat;
    logic                   start;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [OUTW-1:0] out_re;
    logic signed [OUTW-1:0] out_im;
    logic [3:0]             out_bin;
    logic                   out_last;
    logic                   out_sat;
    logic                   busy;
    logic                   done;
    logic                   err_overrun;
    logic [38:0]            obs;

    int vectors = 0;
    int miscompares = 0;

    fft_output_streamer #(.N(N), .INW(INW), .OUTW(OUTW), .SHIFT(SH)) dut (
        .clk(clk), .rst_n(rst_n), .yr_flat(yr_flat), .yi_flat(yi_flat), .start(start),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_bin(out_bin), .out_last(out_last), .out_sat(out_sat), .busy(busy),
        .done(done), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    assign obs = {out_valid, out_re, out_im, out_bin, out_last, out_sat};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bin(input int g, input logic signed [INW-1:0] re, input logic signed [INW-1:0] im);
        yr_flat[g*INW +: INW] = re;
        yi_flat[g*INW +: INW] = im;
    endtask

    task automatic load_ramp();
        logic signed [INW-1:0] vr;
        logic signed [INW-1:0] vi;
        for (int g = 0; g < N; g++) begin
            vr = g * 256;
            vi = -g * 256;
            set_bin(g, vr, vi);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Expected beat k for the ramp frame: (k*256, -k*256) >> 4 rounds exactly to (16k, -16k).
    function automatic logic [38:0] ramp_beat(input int k);
        logic signed [15:0] er;
        logic signed [15:0] ei;
        logic [3:0]         eb;
        er = 16'(k * 16);
        ei = 16'(-k * 16);
        eb = 4'(k);
        return {1'b1, er, ei, eb, (k == 15), 1'b0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        load_ramp();
        step();
        step();
        vectors++;
        if (obs !== 39'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h want %h", obs, 39'd0);
        end
        vectors++;
        if ({busy, done, err_overrun} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got %b want 000", {busy, done, err_overrun});
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if ({obs, busy} !== 40'd0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got %h want 0", {obs, busy});
        end
    endtask

    task automatic test_stream();
        load_ramp();
        out_ready = 1'b1;
        start_frame();
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (obs !== ramp_beat(k)) begin
                miscompares++;
                $display("[TB] FAIL stream_beat%0d: got %h want %h", k, obs, ramp_beat(k));
            end
            step();
        end
        vectors++;
        if ({out_valid, done, busy} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL stream_done: got %b want 011", {out_valid, done, busy});
        end
        step();
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL stream_idle: got %b want 00", {done, busy});
        end
    endtask

    task automatic test_round_sat();
        logic signed [15:0] er;
        logic signed [15:0] ei;
        logic [38:0]        ex;
        yr_flat = '0;
        yi_flat = '0;
        set_bin(0, 24, -24);
        set_bin(3, 48'sd1073741824, -48'sd1073741824);
        start_frame();
        for (int k = 0; k < 16; k++) begin
            er = (k == 0) ? 16'sd2 : (k == 3) ? 16'sd32767 : 16'sd0;
            ei = (k == 0) ? -16'sd1 : (k == 3) ? -16'sd32768 : 16'sd0;
            ex = {1'b1, er, ei, 4'(k), (k == 15), (k == 3)};
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("[TB] FAIL round_sat_beat%0d: got %h want %h", k, obs, ex);
            end
            step();
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL round_sat_done: got %b want 1", done);
        end
        step();
    endtask

    task automatic test_backpressure();
        int beats;
        int stall;
        load_ramp();
        out_ready = 1'b1;
        start_frame();
        beats = 0;
        stall = 0;
        for (int cyc = 0; cyc < 64 && out_valid === 1'b1; cyc++) begin
            vectors++;
            if (obs !== ramp_beat(beats)) begin
                miscompares++;
                $display("[TB] FAIL bp_beat%0d_cyc%0d: got %h want %h", beats, cyc, obs, ramp_beat(beats));
            end
            if (beats == 5 && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
                beats++;
            end
            step();
        end
        out_ready = 1'b1;
        vectors++;
        if ({beats, stall} !== {32'd16, 32'd3}) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got beats=%0d stalls=%0d want 16/3", beats, stall);
        end
        vectors++;
        if ({out_valid, done} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL bp_done: got %b want 01", {out_valid, done});
        end
        step();
    endtask

    task automatic test_overrun_reset();
        load_ramp();
        out_ready = 1'b1;
        start_frame();
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (obs !== ramp_beat(k)) begin
                miscompares++;
                $display("[TB] FAIL ovr_beat%0d: got %h want %h", k, obs, ramp_beat(k));
            end
            if (k == 8) begin
                load_ramp();
                vectors++;
                if (err_overrun !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL ovr_flag: got %b want 1", err_overrun);
                end
            end
            if (k == 7) begin
                start = 1'b1;
                yr_flat = '1;
                yi_flat = '1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        vectors++;
        if ({done, err_overrun} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL ovr_sticky: got %b want 11", {done, err_overrun});
        end
        step();
        start_frame();
        vectors++;
        if ({err_overrun, obs} !== {1'b0, ramp_beat(0)}) begin
            miscompares++;
            $display("[TB] FAIL ovr_clear: got %h want %h", {err_overrun, obs}, {1'b0, ramp_beat(0)});
        end
        for (int k = 0; k < 10; k++) step();
        vectors++;
        if (obs !== ramp_beat(10)) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_beat10: got %h want %h", obs, ramp_beat(10));
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({obs, busy, done, err_overrun} !== 42'd0) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: got %h want 0", {obs, busy, done, err_overrun});
        end
        step();
        rst_n = 1'b1;
        step();
        start_frame();
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (obs !== ramp_beat(k)) begin
                miscompares++;
                $display("[TB] FAIL post_reset_beat%0d: got %h want %h", k, obs, ramp_beat(k));
            end
            step();
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_done: got %b want 1", done);
        end
        step();
    endtask

    task automatic test_bitrev();
        int exp_bins [4] = '{0, 8, 4, 12};
        logic signed [INW-1:0] v;
        logic [19:0] ex;
        yr_flat = '0;
        yi_flat = '0;
        for (int g = 0; g < N; g++) begin
            v = g;
            set_bin(g, v, '0);
        end
        out_ready = 1'b1;
        start_frame();
        for (int k = 0; k < 4; k++) begin
            ex = {4'(exp_bins[k]), 16'((exp_bins[k] + 1) / 2)};
            vectors++;
            if ({out_bin, out_re} !== ex) begin
                miscompares++;
                $display("[TB] FAIL bitrev_beat%0d: got %h want %h", k, {out_bin, out_re}, ex);
            end
            step();
        end
        for (int k = 4; k < 16; k++) step();
        vectors++;
        if ({out_valid, done} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL bitrev_done: got %b want 01", {out_valid, done});
        end
        step();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        yr_flat = '0;
        yi_flat = '0;
        test_reset();
`ifdef FFT_OUT_BITREV_EN
        test_bitrev();
`else
        test_stream();
        test_round_sat();
        test_backpressure();
        test_overrun_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_output_streamer.md
FFT_OUTPUT_STREAMER -- requirements
Module: fft_output_streamer

Interface
REQ-001 Parameter N, default 16: number of FFT bins; fixed at 16, so the index width is 4.
REQ-002 Parameter INW, default 48: width of each stage-2 result word.
REQ-003 Parameter OUTW, default 16: width of each streamed output word.
REQ-004 Parameter SHIFT, default 4: right-shift scaling applied to each word; legal range is 1..INW-OUTW.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port yr_flat, input, N*INW bits: stage-2 real results; bin g occupies bits [(g+1)*INW-1 : g*INW], signed.
REQ-008 Port yi_flat, input, N*INW bits: stage-2 imaginary results, packed the same way as yr_flat, signed.
REQ-009 Port start, input, 1 bit: yr_flat/yi_flat are valid this cycle and shall be snapshotted.
REQ-010 Port out_valid, output, 1 bit: a beat is presented.
REQ-011 Port out_ready, input, 1 bit: the sink accepts the beat.
REQ-012 Port out_re, output, OUTW bits, signed: scaled real part of the current bin.
REQ-013 Port out_im, output, OUTW bits, signed: scaled imaginary part of the current bin.
REQ-014 Port out_bin, output, 4 bits: bin number carried by the current beat.
REQ-015 Port out_last, output, 1 bit: asserted on the 16th beat of a frame.
REQ-016 Port out_sat, output, 1 bit: the current beat's re or im value saturated.
REQ-017 Port busy, output, 1 bit: high when the FSM is not in IDLE.
REQ-018 Port done, output, 1 bit: one-cycle pulse after the final beat completes.
REQ-019 Port err_overrun, output, 1 bit: sticky; start was asserted while busy.

Function
REQ-020 The FSM shall have three states, IDLE, STREAM and DONE, with transitions IDLE->STREAM, STREAM->DONE and DONE->IDLE.
REQ-021 In IDLE, a sampled start shall latch all 2N input words into snapshot registers, set beat counter = 0, load beat 0 into the output registers and enter STREAM.
REQ-022 out_valid shall be high throughout STREAM, rising in the cycle after start is sampled (one-cycle latency).
REQ-023 A handshake occurs when out_valid and out_ready are both high; each handshake increments the beat counter and loads the next beat into the output registers at that edge.
REQ-024 While out_valid is high and out_ready is low, out_re, out_im, out_bin, out_last and out_sat shall hold stable.
REQ-025 The handshake on the beat with counter 15 shall end the frame: out_valid falls, the FSM enters DONE, and done pulses for exactly one cycle; the FSM then returns to IDLE.
REQ-026 Beat scaling shall compute r = (x + 2^(SHIFT-1)) >>> SHIFT in INW+1 bits (round half up, arithmetic shift).
REQ-027 The result r shall saturate to [-2^(OUTW-1), 2^(OUTW-1)-1]; out_sat is the OR of the re and im saturation flags for that beat.
REQ-028 A start sampled while in STREAM or DONE shall be ignored and shall set err_overrun; the snapshot registers are not disturbed.
REQ-029 err_overrun shall clear when start is accepted in IDLE.
REQ-030 In IDLE, out_re, out_im, out_bin, out_last and out_sat shall hold 0.
REQ-031 The beat counter shall wrap from 15 to 0 only on frame end; out_last shall equal (counter == 15) while out_valid is high.

Reset
REQ-032 Asserting rst_n low at any time, including mid-frame, shall immediately force the FSM to IDLE and drive all outputs and the beat counter to 0; the partial frame is discarded.
REQ-033 The snapshot registers shall reset to 0.
REQ-034 After rst_n deasserts, the first start shall be accepted normally.

Configuration
REQ-035 Macro FFT_OUT_BITREV_EN controls beat ordering.
REQ-036 When FFT_OUT_BITREV_EN is defined, beat k shall carry snapshot index bitrev4(k), and out_bin shall equal bitrev4(k).
REQ-037 When FFT_OUT_BITREV_EN is undefined, beat k shall carry snapshot index k, and out_bin shall equal k.

Verification
REQ-038 Bin g = (g*256, -g*256), out_ready held at 1, macro off: 16 consecutive beats with out_re = g*16, out_im = -g*16, out_bin = g; out_last on beat 15; done one cycle later.
REQ-039 Rounding: bin 0 = (24, -24): out_re = 2, out_im = -1, out_sat = 0.
REQ-040 Saturation: bin 3 = (2^30, -2^30): out_re = 32767, out_im = -32768, out_sat = 1 on that beat only.
REQ-041 Backpressure: drop out_ready for 3 cycles during beat 5: outputs hold stable, no beat is lost or duplicated, and the total is 16 beats.
REQ-042 Overrun and reset: pulse start during beat 7: err_overrun = 1 and the stream is unchanged; then assert rst_n low at beat 10: all outputs are 0 and the next start streams from beat 0.
REQ-043 With FFT_OUT_BITREV_EN defined and bin g = (g, 0), SHIFT = 1: beats 0..3 carry out_bin = 0, 8, 4, 12 in that order.
